// File: rtl/ram_r_w_s_dff_if.sv
// Access bus for the flop-based RAM: chip select, write strobe, both addresses, write and read data.
// Latency: none in the bus itself; read data is combinational from the RAM and writes land on the clock edge.
// Backpressure: none, because every access completes unconditionally.
// Ports: cs_n/wr_n are active-low controls, rd_addr/wr_addr are aw bits wide, and data_in/data_out are data_width bits wide.
// master drives the controls, addresses and write data. slave (the RAM) drives data_out.
interface ram_r_w_s_dff_if #(
   parameter int data_width = 16,
   parameter int aw         = 3
);
   logic                  cs_n;
   logic                  wr_n;
   logic [aw-1:0]         rd_addr;
   logic [aw-1:0]         wr_addr;
   logic [data_width-1:0] data_in;
   logic [data_width-1:0] data_out;

   modport master (
      output cs_n, wr_n, rd_addr, wr_addr, data_in,
      input  data_out
   );

   modport slave (
      input  cs_n, wr_n, rd_addr, wr_addr, data_in,
      output data_out
   );
endinterface

// File: rtl/ram_r_w_s_dff.sv
// Flip-flop RAM with one synchronous write port and one combinational read port. The whole array is cleared by reset.
// Latency: a write lands at the rising clock edge, and data_out = mem[rd_addr] in the same cycle, with no write-through bypass.
// Backpressure: none, because every access completes in the cycle it is presented.
// Ports: clock, reset_n (active-low; asynchronous when rst_mode=0, sampled at posedge when rst_mode=1),
//        bus (slave modport): cs_n, wr_n, rd_addr, wr_addr, data_in in; data_out out.
module ram_r_w_s_dff #(
   parameter int data_width = 16,
   parameter int depth      = 8,
   parameter int rst_mode   = 0
) (
   input  logic           clock,
   input  logic           reset_n,
   ram_r_w_s_dff_if.slave bus
);

   localparam int aw = (depth > 2) ? $clog2(depth) : 1;

   // The depth is held one bit wider than an address so that depth=2^aw stays representable in range compares.
   localparam logic [aw:0] depth_lim = depth[aw:0];

   logic [data_width-1:0] mem [depth];

   logic wr_in_range;
   logic rd_in_range;
   logic wr_en;

   // Addresses at or beyond depth exist only when depth is not a power of two.
   // Writes to those addresses are dropped, and reads from them return zero.
   assign wr_in_range = ({1'b0, bus.wr_addr} < depth_lim);
   assign rd_in_range = ({1'b0, bus.rd_addr} < depth_lim);
   assign wr_en       = !bus.cs_n && !bus.wr_n && wr_in_range;

   generate
      if (rst_mode == 0) begin : g_async_rst
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < depth; i++) begin
                  mem[i] <= '0;
               end
            end else if (wr_en) begin
               mem[bus.wr_addr] <= bus.data_in;
            end
         end
      end else begin : g_sync_rst
         always_ff @(posedge clock) begin
            if (!reset_n) begin
               for (int i = 0; i < depth; i++) begin
                  mem[i] <= '0;
               end
            end else if (wr_en) begin
               mem[bus.wr_addr] <= bus.data_in;
            end
         end
      end
   endgenerate

   // The read path is combinational and ignores cs_n and wr_n.
   assign bus.data_out = rd_in_range ? mem[bus.rd_addr] : '0;

`ifndef SYNTHESIS
   initial begin
      if (data_width < 1 || data_width > 256)
         $fatal(1, "ram_r_w_s_dff: illegal data_width %0d (legal 1..256)", data_width);
      if (depth < 2 || depth > 256)
         $fatal(1, "ram_r_w_s_dff: illegal depth %0d (legal 2..256)", depth);
      if (rst_mode != 0 && rst_mode != 1)
         $fatal(1, "ram_r_w_s_dff: illegal rst_mode %0d (legal 0 or 1)", rst_mode);
   end
`endif

endmodule

// File: tb/tb_ram_r_w_s_dff.sv
module tb_ram_r_w_s_dff;

   localparam int DW    = 8;
   localparam int DEPTH = 6;
   localparam int AW    = 3;

   logic clock;
   logic reset_n;

   ram_r_w_s_dff_if #(.data_width(DW), .aw(AW)) bus ();

   ram_r_w_s_dff #(
      .data_width (DW),
      .depth      (DEPTH),
      .rst_mode   (0)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass;
   int n_total;

   // The reference model is the memory contents as a plain array.
   // Out-of-range reads return zero, and out-of-range writes are dropped.
   logic [DW-1:0] model [DEPTH];

   function automatic logic [DW-1:0] model_read(input int addr);
      if (addr < DEPTH) return model[addr];
      return '0;
   endfunction

   task automatic model_write(input logic cs_n, input logic wr_n, input int addr, input logic [DW-1:0] d);
      if (!cs_n && !wr_n && addr < DEPTH) model[addr] = d;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: data_out=%h expected=%h at t=%0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic cs_n, input logic wr_n, input int wa, input logic [DW-1:0] d, input int ra);
      bus.cs_n    = cs_n;
      bus.wr_n    = wr_n;
      bus.wr_addr = wa[AW-1:0];
      bus.data_in = d;
      bus.rd_addr = ra[AW-1:0];
   endtask

   typedef struct {
      string         name;
      logic          cs_n;
      logic          wr_n;
      int            wr_addr;
      logic [DW-1:0] data_in;
      int            rd_addr;
      logic [DW-1:0] exp_before;
      logic [DW-1:0] exp_after;
   } vec_t;

   vec_t vecs [12];

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset_n = 1'b0;
      drive(1'b1, 1'b1, 0, '0, 0);
      model_clear();

      vecs[0]  = '{"wr_a5_at3",      1'b0, 1'b0, 3, 8'hA5, 3, 8'h00, 8'hA5};
      vecs[1]  = '{"rd2_empty",      1'b1, 1'b1, 2, 8'hFF, 2, 8'h00, 8'h00};
      vecs[2]  = '{"cs_off_wr1",     1'b1, 1'b0, 1, 8'h11, 1, 8'h00, 8'h00};
      vecs[3]  = '{"wr_off_wr1",     1'b0, 1'b1, 1, 8'h11, 1, 8'h00, 8'h00};
      vecs[4]  = '{"cs_hi_rd3",      1'b1, 1'b1, 0, 8'h00, 3, 8'hA5, 8'hA5};
      vecs[5]  = '{"cs_lo_rd3",      1'b0, 1'b1, 0, 8'h00, 3, 8'hA5, 8'hA5};
      vecs[6]  = '{"same_addr4",     1'b0, 1'b0, 4, 8'h3C, 4, 8'h00, 8'h3C};
      vecs[7]  = '{"oor_wr7_rd7",    1'b0, 1'b0, 7, 8'hFF, 7, 8'h00, 8'h00};
      vecs[8]  = '{"oor_wr6_rd6",    1'b0, 1'b0, 6, 8'hEE, 6, 8'h00, 8'h00};
      vecs[9]  = '{"wr77_at5",       1'b0, 1'b0, 5, 8'h77, 5, 8'h00, 8'h77};
      vecs[10] = '{"rd3_while_wr0",  1'b0, 1'b0, 0, 8'h42, 3, 8'hA5, 8'hA5};
      vecs[11] = '{"rd0_after_wr",   1'b1, 1'b1, 0, 8'h00, 0, 8'h42, 8'h42};

      // Reset.
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         bus.rd_addr = a[AW-1:0];
         #1;
         check($sformatf("reset_rd%0d", a), bus.data_out, 8'h00);
      end

      // Table-driven directed vectors.
      for (int v = 0; v < 12; v++) begin
         @(negedge clock);
         drive(vecs[v].cs_n, vecs[v].wr_n, vecs[v].wr_addr, vecs[v].data_in, vecs[v].rd_addr);
         #1;
         check({vecs[v].name, "_pre"}, bus.data_out, vecs[v].exp_before);
         @(posedge clock);
         model_write(vecs[v].cs_n, vecs[v].wr_n, vecs[v].wr_addr, vecs[v].data_in);
         #1;
         check({vecs[v].name, "_post"}, bus.data_out, vecs[v].exp_after);
      end

      // The out-of-range writes must not have disturbed any in-range word.
      @(negedge clock);
      drive(1'b1, 1'b1, 0, '0, 0);
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = a[AW-1:0];
         #1;
         check($sformatf("after_oor_rd%0d", a), bus.data_out, model_read(a));
      end

      // Fill every word with 0x5A, then assert reset between clock edges.
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clock);
         drive(1'b0, 1'b0, a, 8'h5A, a);
         @(posedge clock);
         model_write(1'b0, 1'b0, a, 8'h5A);
      end
      @(negedge clock);
      drive(1'b1, 1'b1, 0, '0, 2);
      #1;
      check("fill_rd2", bus.data_out, 8'h5A);
      #1;
      reset_n = 1'b0;
      model_clear();
      #1;
      check("async_rst_no_edge", bus.data_out, 8'h00);
      drive(1'b0, 1'b0, 2, 8'h99, 2);
      @(posedge clock);
      #1;
      check("wr_blocked_in_rst", bus.data_out, 8'h00);
      @(negedge clock);
      drive(1'b1, 1'b1, 0, '0, 0);
      reset_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = a[AW-1:0];
         #1;
         check($sformatf("post_rst_rd%0d", a), bus.data_out, 8'h00);
      end

      // Randomized traffic against the model, with occasional mid-cycle resets.
      for (int it = 0; it < 300; it++) begin
         logic          r_cs, r_wr;
         int            r_wa, r_ra;
         logic [DW-1:0] r_d;
         @(negedge clock);
         r_cs = ($urandom_range(0, 3) == 0);
         r_wr = ($urandom_range(0, 3) == 0);
         r_wa = $urandom_range(0, 7);
         r_ra = $urandom_range(0, 7);
         r_d  = DW'($urandom);
         if ($urandom_range(0, 2) == 0) r_ra = r_wa;
         drive(r_cs, r_wr, r_wa, r_d, r_ra);
         #1;
         check($sformatf("rand%0d_pre", it), bus.data_out, model_read(r_ra));
         if (it % 75 == 74) begin
            reset_n = 1'b0;
            model_clear();
            #1;
            check($sformatf("rand%0d_rst", it), bus.data_out, 8'h00);
            @(posedge clock);
            #1;
            check($sformatf("rand%0d_rst_post", it), bus.data_out, 8'h00);
            @(negedge clock);
            reset_n = 1'b1;
         end else begin
            @(posedge clock);
            model_write(r_cs, r_wr, r_wa, r_d);
            #1;
            check($sformatf("rand%0d_post", it), bus.data_out, model_read(r_ra));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
